// File: rtl/shared_timer_scheduler.sv
// Shares one prescaled countdown timer among N_REQ requesters with round-robin arbitration.
// Each grant times req_ticks ticks of PRESCALE cycles, then pulses done to the owner.
module shared_timer_scheduler #(
  parameter int N_REQ    = 4,
  parameter int DLY_W    = 8,
  parameter int PRESCALE = 800000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DLY_W-1:0]   req_ticks,
  input  logic                     abort,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] active_id
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int ID_W = $clog2(N_REQ);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [ID_W-1:0]    ptr_r, id_r, winner_s;
  logic [PS_W-1:0]    presc_r;
  logic [DLY_W-1:0]   remain_r, slice_s;
  logic               pend_r, found_s, tick_s, last_s;
  logic [N_REQ-1:0]   grant_r, done_r, grant_s, done_s;
  logic               busy_r, busy_s;

  // Index arithmetic modulo N_REQ, valid for non-power-of-two counts.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N_REQ) s = s - N_REQ;
    else            s = s;
    return ID_W'(s);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin arbiter: first asserted request at or after the pointer.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found_s && req[wrap_add(ptr_r, i)]) begin
        found_s  = 1'b1;
        winner_s = wrap_add(ptr_r, i);
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign slice_s = req_ticks[int'(winner_s)*DLY_W +: DLY_W];
  assign tick_s  = (presc_r == PS_MAX);
  assign last_s  = tick_s && (remain_r == DLY_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic; abort outranks the final tick.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) state_s = (slice_s == '0) ? DONE : RUN;
        else         state_s = IDLE;
      end
      RUN: begin
        if (abort)       state_s = IDLE;
        else if (last_s) state_s = DONE;
        else             state_s = RUN;
      end
      DONE: begin
        if (pend_r) state_s = DONE;
        else        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode, registered below.
  always_comb begin
    grant_s = '0;
    done_s  = '0;
    busy_s  = (state_s != IDLE);
    case (state_r)
      IDLE: begin
        if (found_s) grant_s = onehot(winner_s);
        else         grant_s = '0;
      end
      RUN: begin
        if (!abort && last_s) done_s = onehot(id_r);
        else                  done_s = '0;
      end
      DONE: begin
        if (pend_r) done_s = onehot(id_r);
        else        done_s = '0;
      end
      default: begin
        grant_s = '0;
        done_s  = '0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_r <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      grant_r <= grant_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  // Timer datapath; pend_r defers done by one cycle for zero-tick requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r    <= '0;
      id_r     <= '0;
      presc_r  <= '0;
      remain_r <= '0;
      pend_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            id_r     <= winner_s;
            remain_r <= slice_s;
            presc_r  <= '0;
            pend_r   <= (slice_s == '0);
          end else begin
            presc_r  <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            presc_r <= '0;
            ptr_r   <= wrap_add(id_r, 1);
          end else if (tick_s) begin
            presc_r  <= '0;
            remain_r <= remain_r - DLY_W'(1);
          end else begin
            presc_r  <= presc_r + PS_W'(1);
          end
        end
        DONE: begin
          if (pend_r) pend_r <= 1'b0;
          else        ptr_r  <= wrap_add(id_r, 1);
        end
        default: begin
          presc_r <= '0;
          pend_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign active_id = id_r;

endmodule

// File: tb/tb_shared_timer_scheduler.sv
// Bench for shared_timer_scheduler: directed scenarios then random traffic, checked every
// cycle against a service-level model that predicts grant/done/busy times arithmetically.
module tb_shared_timer_scheduler;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_ticks = '0;
  logic           abort = 1'b0;
  logic [N-1:0]   grant, done;
  logic           busy;
  logic [1:0]     active_id;

  shared_timer_scheduler #(.N_REQ(N), .DLY_W(W), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .req(req), .req_ticks(req_ticks), .abort(abort),
    .grant(grant), .done(done), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int e = 0;
  logic [W-1:0] tk [N];

  // Model state: times are cycle numbers (cycle e follows posedge e).
  int ptr = 0, owner = 0, g_cyc = -10, d_cyc = -10, busy_end = -10, idle_edge = 1;
  bit done_ok = 1'b0, has_run = 1'b0;

  task automatic step(input logic [N-1:0] r, input logic ab, input logic rs);
    int win, t;
    logic [N-1:0] eg, ed;
    logic eb;
    req = r; abort = ab; rst = rs;
    req_ticks = {tk[3], tk[2], tk[1], tk[0]};
    @(posedge clk);
    e++;
    if (!rs) begin
      ptr = 0; owner = 0; g_cyc = -10; d_cyc = -10; busy_end = -10;
      done_ok = 1'b0; has_run = 1'b0; idle_edge = e + 1;
    end else if (e >= idle_edge) begin
      if (r != '0) begin
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && r[(ptr + k) % N]) win = (ptr + k) % N;
        t = int'(tk[win]);
        owner = win; ptr = (win + 1) % N; g_cyc = e;
        d_cyc = (t == 0) ? e + 1 : e + t * P;
        has_run = (t != 0); done_ok = 1'b1;
        busy_end = d_cyc; idle_edge = d_cyc + 2;
      end
    end else if (ab && has_run && done_ok && (e - 1 >= g_cyc) && (e - 1 <= d_cyc - 1)) begin
      done_ok = 1'b0; busy_end = e - 1; idle_edge = e + 1;
    end
    eg = (e == g_cyc) ? (N'(1) << owner) : '0;
    ed = (done_ok && e == d_cyc) ? (N'(1) << owner) : '0;
    eb = (e >= g_cyc) && (e <= busy_end);
    #1;
    total++;
    assert (grant === eg) else begin bad++; $error("FAIL grant cyc=%0d got=%b want=%b", e, grant, eg); end
    total++;
    assert (done === ed) else begin bad++; $error("FAIL done cyc=%0d got=%b want=%b", e, done, ed); end
    total++;
    assert (busy === eb) else begin bad++; $error("FAIL busy cyc=%0d got=%b want=%b", e, busy, eb); end
    total++;
    assert (active_id === 2'(owner)) else begin bad++; $error("FAIL active_id cyc=%0d got=%0d want=%0d", e, active_id, owner); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) tk[i] = 8'd0;
    // Reset.
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    idle(2);
    // 1: single request, three ticks.
    tk[1] = 8'd3;
    step(4'b0010, 1'b0, 1'b1);
    idle(16);
    // 2: all requesting, one tick each, rotation 0,1,2,3,0.
    for (int i = 0; i < N; i++) tk[i] = 8'd1;
    for (int i = 0; i < 32; i++) step(4'b1111, 1'b0, 1'b1);
    idle(4);
    // 3: zero-tick request.
    tk[2] = 8'd0;
    step(4'b0100, 1'b0, 1'b1);
    idle(5);
    // 4: abort a five-tick timer, then all request.
    tk[0] = 8'd5;
    step(4'b0001, 1'b0, 1'b1);
    idle(10);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    idle(8);
    // Abort coinciding with the final tick.
    tk[2] = 8'd2;
    step(4'b0100, 1'b0, 1'b1);
    idle(7);
    step(4'b0000, 1'b1, 1'b1);
    idle(4);
    // 5: reset mid-run, then scenario 1 again.
    tk[1] = 8'd3;
    step(4'b0010, 1'b0, 1'b1);
    idle(5);
    step(4'b0000, 1'b0, 1'b0);
    idle(3);
    step(4'b0010, 1'b0, 1'b1);
    idle(16);
    // 6: short pulse while busy is dropped; owner re-request waits its turn.
    tk[0] = 8'd2; tk[2] = 8'd1;
    step(4'b0001, 1'b0, 1'b1);
    step(4'b1001, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(4'b0101, 1'b0, 1'b1);
    idle(4);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) tk[k] = 8'($urandom_range(0, 3));
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 149) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_timer_scheduler.md
Name: shared_timer_scheduler

Overview:
- Time-shares one prescaled countdown timer among N_REQ requesters, round-robin.
- Each requester asks for a delay in ticks; the block grants, times the delay, then pulses that requester's done.
- Replaces per-function free-running half-second counters with a single timer resource.
- The prescaler is internal: one tick every PRESCALE clk cycles.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DLY_W, 8, width of each requested tick count.
- PRESCALE, 800000, clk cycles per tick (>=2); PS_W = clog2(PRESCALE), max 25 bits.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- req  input  N_REQ  request per requester; level, held until grant.
- req_ticks  input  N_REQ*DLY_W  delay per requester; slice i = bits [i*DLY_W +: DLY_W]; sampled at grant.
- abort  input  1  cancels the timer currently running.
- grant  output  N_REQ  one-hot, 1-cycle pulse: request accepted.
- done  output  N_REQ  one-hot, 1-cycle pulse: granted delay expired.
- busy  output  1  high while state != IDLE.
- active_id  output  clog2(N_REQ)  index of current owner; holds last owner when idle.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at posedge) applies in any state, including mid-RUN:
  - state=IDLE; grant=0; done=0; busy=0; active_id=0.
  - Round-robin pointer=0; prescaler=0; remaining=0.
  - No done is issued for an interrupted timer.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is high at a posedge, pick the winner: first asserted index at or after the pointer, wrapping modulo N_REQ.
  - On that edge: grant[winner]=1 for one cycle; active_id=winner; remaining=req_ticks slice; prescaler=0; busy=1.
  - Next state: RUN if the slice is nonzero, else DONE.
  - No req high: stay in IDLE.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler==PRESCALE-1 (the tick): prescaler=0 and remaining decrements.
  - If remaining==1 at the tick: done[active_id]=1 and state=DONE.
- DONE:
  - done is high for exactly this one cycle.
  - Pointer=active_id+1 (mod N_REQ); state=IDLE; busy=0 on the following edge.
- Latency:
  - Grant appears in cycle g.
  - done appears in cycle g+T*PRESCALE for T>=1.
  - done appears in cycle g+1 for T=0.
  - The next grant is no earlier than the done cycle +2.
- abort:
  - Sampled only in RUN. State goes to IDLE; no done pulse; pointer=active_id+1; prescaler clears.
  - Ignored in IDLE and DONE.
- Requester rules:
  - A requester deasserting req before its grant withdraws the request without side effects.
  - req from the current owner while RUN/DONE is ignored.
  - After done, the owner must re-request to be served again. req still high at IDLE counts as a new request, subject to round-robin.
- Arithmetic:
  - remaining is DLY_W bits and never underflows, since T=0 bypasses RUN.
  - The prescaler wraps only via the compare; there is no free-running overflow.
- Simultaneous events:
  - abort and the final tick in the same cycle: abort wins, no done.
  - Multiple req bits: exactly one grant, chosen by round-robin.

Test Plan:
1. PRESCALE=4. req[1]=1, req_ticks[1]=3 in IDLE at cycle 0 → grant=0b0010 in cycle 1; busy=1; done=0b0010 in cycle 13 only; busy=0 from cycle 14.
2. req=0b1111 held continuously, all ticks=1 → grants in order 0,1,2,3,0; each done 4 cycles after its grant; exactly one grant and one done bit per service.
3. req[2]=1 with ticks=0 → grant in cycle g, done[2] in cycle g+1; prescaler never ticks.
4. PRESCALE=4, ticks=5; abort asserted at g+10 → busy falls by g+11; no done pulse ever; the next requester after index 0 is served first.
5. rst=0 asserted mid-RUN at g+6 → the next cycle shows all outputs 0 and state IDLE; no done; a subsequent request at pointer 0 behaves as in scenario 1.
6. req[3] pulsed for 1 cycle while busy, then dropped → never granted; req[0] held while owner 0 is running → ignored until IDLE, then granted after the lower-priority waiters per the pointer.
